data_reg_ctr: RTL

//   Parametrised data register / up-down counter: successor to the fixed 16-bit DR

---
 rtl/data_reg_ctr.sv | 121 ++++++++++++
 1 files changed

// File: rtl/data_reg_ctr.sv
// data_reg_ctr: parametrised data register / up-down counter
// load, inc/dec (wrap or saturate), logical shifts, registered flags
module data_reg_ctr #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned RST_VAL  = 0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LD,
  input  logic             INC,
  input  logic             DEC,
  input  logic             SHL,
  input  logic             SHR,
  input  logic             SER_IN,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] D_OUT,
  output logic             CO,
  output logic             ZERO,
  output logic             LIMIT
);

  localparam logic [WIDTH-1:0] RV  = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LD,
    OP_INC,
    OP_DEC,
    OP_SHL,
    OP_SHR
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             lim;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             at_max;
  logic             at_min;

  // carry out of q+1 marks all-ones; borrow of q-1 marks zero
  assign sum    = {1'b0, q} + ONE;
  assign dif    = {1'b0, q} - ONE;
  assign at_max = sum[WIDTH];
  assign at_min = dif[WIDTH];

  // pick the single operation for this edge by fixed priority
  always_comb begin
    op = OP_HOLD;
    if (LD)
      op = OP_LD;
    else if (INC && DEC)
      op = OP_HOLD;
    else if (INC)
      op = OP_INC;
    else if (DEC)
      op = OP_DEC;
    else if (SHL)
      op = OP_SHL;
    else if (SHR)
      op = OP_SHR;
  end

  // register, carry and boundary pulse update
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q   <= RV;
      co  <= 1'b0;
      lim <= 1'b0;
    end else begin
      lim <= 1'b0;
      case (op)
        OP_LD: begin
          q  <= D_IN;
          co <= 1'b0;
        end
        OP_INC: begin
          co <= at_max;
          if (at_max) begin
            lim <= 1'b1;
            if (!SATURATE)
              q <= sum[WIDTH-1:0];
          end else begin
            q <= sum[WIDTH-1:0];
          end
        end
        OP_DEC: begin
          co <= at_min;
          if (at_min) begin
            lim <= 1'b1;
            if (!SATURATE)
              q <= dif[WIDTH-1:0];
          end else begin
            q <= dif[WIDTH-1:0];
          end
        end
        OP_SHL: begin
          q  <= {q[WIDTH-2:0], SER_IN};
          co <= q[WIDTH-1];
        end
        OP_SHR: begin
          q  <= {SER_IN, q[WIDTH-1:1]};
          co <= q[0];
        end
        default: begin
          q  <= q;
          co <= co;
        end
      endcase
    end
  end

  assign D_OUT = q;
  assign CO    = co;
  assign LIMIT = lim;
  assign ZERO  = (q == '0);

endmodule
